// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port B arbiter: requester ids,
// lock FSM states and the tag carried alongside each in-flight read.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        LK_OPEN    = 2'd0,
        LK_PENDING = 2'd1,
        LK_LOCKED  = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_NONE = '{valid: 1'b0, id: REQ_R0};

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// Read-response tag pipe: one stage per cycle of memory read latency.
// The tail stage lines up with the cycle the memory presents read data.
// has_r0_o flags any outstanding R0 read so the lock FSM can wait it out.
module dmem_arb_rsp_pipe
    import dmem_arb_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tail_o,
    output logic    has_r0_o
);

    rd_tag_t             stage_q [READ_LAT];
    logic [READ_LAT-1:0] r0_hit;

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= RD_TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < READ_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_hit
        assign r0_hit[gi] = stage_q[gi].valid && (stage_q[gi].id == REQ_R0);
    end

    assign tail_o   = stage_q[READ_LAT-1];
    assign has_r0_o = |r0_hit;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for port B of the unified instruction/data memory.
// R0 = load/store unit, R1 = UART loader / debug master (can lock the port).
// One access per cycle; reads return READ_LAT cycles later, to the issuer only.
// Optional feature: define ARB_RR_EN for round-robin arbitration while the
// lock is open; otherwise R1 has fixed priority over R0.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              r1_lock,
    output logic              r1_owned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    lock_state_e       lock_q, lock_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              r0_gnt, r1_gnt;
    rd_tag_t           issue_tag, tail_tag;
    logic              pipe_has_r0;

`ifdef ARB_RR_EN
    // Last requester granted; the other one wins the next contested cycle.
    req_id_e last_q, last_d;
`endif

    // Grant: R0 only while the lock is open; R1 always eligible.
    // Reset forces both grants low so nothing reaches the memory.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (lock_q != LK_OPEN) begin
                r1_gnt = r1_valid;
            end else if (r0_valid && r1_valid) begin
`ifdef ARB_RR_EN
                if (last_q == REQ_R1) begin
                    r0_gnt = 1'b1;
                end else begin
                    r1_gnt = 1'b1;
                end
`else
                r1_gnt = 1'b1;
`endif
            end else begin
                r0_gnt = r0_valid;
                r1_gnt = r1_valid;
            end
        end
    end

    // Port B drive: winner's fields when granted, otherwise hold last address/data.
    always_comb begin
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mem_we          = 1'b0;
        issue_tag       = RD_TAG_NONE;
        if (r1_gnt) begin
            addr_d          = r1_addr;
            wdata_d         = r1_wdata;
            mem_we          = r1_we;
            issue_tag.valid = !r1_we;
            issue_tag.id    = REQ_R1;
        end else if (r0_gnt) begin
            addr_d          = r0_addr;
            wdata_d         = r0_wdata;
            mem_we          = r0_we;
            issue_tag.valid = !r0_we;
            issue_tag.id    = REQ_R0;
        end
    end

    // Lock FSM next state: PENDING drains outstanding R0 reads before LOCKED.
    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            LK_OPEN:    if (r1_lock) lock_d = LK_PENDING;
            LK_PENDING: begin
                if (!r1_lock) begin
                    lock_d = LK_OPEN;
                end else if (!pipe_has_r0) begin
                    lock_d = LK_LOCKED;
                end
            end
            LK_LOCKED:  if (!r1_lock) lock_d = LK_OPEN;
            default:    lock_d = LK_OPEN;
        endcase
    end

    // State and held port B address/data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= LK_OPEN;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            lock_q  <= lock_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin pointer follows the most recent winner.
    always_comb begin
        last_d = last_q;
        if (r0_gnt) begin
            last_d = REQ_R0;
        end else if (r1_gnt) begin
            last_d = REQ_R1;
        end
    end

    // Pointer register; reset value R0 hands the first contested grant to R1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_R0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    dmem_arb_rsp_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_i    (issue_tag),
        .tail_o   (tail_tag),
        .has_r0_o (pipe_has_r0)
    );

    assign r0_ready  = r0_gnt;
    assign r1_ready  = r1_gnt;
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;
    assign r1_owned  = (lock_q == LK_LOCKED);
    assign r0_rvalid = tail_tag.valid && (tail_tag.id == REQ_R0);
    assign r1_rvalid = tail_tag.valid && (tail_tag.id == REQ_R1);
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: memory macro model on port B plus a
// transaction-level reference (response queue with due cycles, shadow memory).
module tb_dmem_port_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_we, r0_ready, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_we, r1_ready, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          r1_lock, r1_owned;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .r1_lock(r1_lock), .r1_owned(r1_owned),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Memory macro port B: write-first, LAT-cycle read latency.
    bit   [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [LAT];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) mem_arr[pre_addr] <= pre_data;
        else if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_we ? mem_wdata : mem_arr[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model state.
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    bit   [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            lk = 0;          // 0 open, 1 pending, 2 locked
    bit            last_r1 = 1'b0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    bit            g0, g1;
    logic [5:0]       exp_ctl;
    logic [63:0]      exp_rd;
    logic [AW+DW-1:0] exp_port;

    wire [5:0]       dut_ctl  = {r0_ready, r1_ready, r0_rvalid, r1_rvalid, r1_owned, mem_we};
    wire [63:0]      dut_rd   = {r0_rdata, r1_rdata};
    wire [AW+DW-1:0] dut_port = {mem_addr, mem_wdata};

    int checks = 0;
    int passed = 0;

    task automatic model_reset();
        rq.delete();
        lk         = 0;
        last_r1    = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
    endtask

    // Expected outputs for the current cycle from the current inputs.
    task automatic model_eval();
        bit v0, v1, w;
        logic [DW-1:0] d0, d1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (lk != 0) g1 = r1_valid;
        else if (r0_valid && r1_valid) begin
`ifdef ARB_RR_EN
            if (last_r1) g0 = 1'b1; else g1 = 1'b1;
`else
            g1 = 1'b1;
`endif
        end else begin
            g0 = r0_valid;
            g1 = r1_valid;
        end
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                if (rq[i].id) begin v1 = 1'b1; d1 = rq[i].data; end
                else begin v0 = 1'b1; d0 = rq[i].data; end
            end
        end
        w = (g0 && r0_we) || (g1 && r1_we);
        exp_ctl = {g0, g1, v0, v1, (lk == 2), w};
        exp_rd  = {d0, d1};
        if (g1)      exp_port = {r1_addr, r1_wdata};
        else if (g0) exp_port = {r0_addr, r0_wdata};
        else         exp_port = {last_addr, last_wdata};
    endtask

    // Advance the model across a clock edge (inputs still as sampled).
    task automatic model_commit();
        int r0_out;
        bit we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        r0_out = 0;
        foreach (rq[i]) if (!rq[i].id && rq[i].due >= cyc) r0_out++;
        if (g0 || g1) begin
            we = g1 ? r1_we : r0_we;
            a  = g1 ? r1_addr : r0_addr;
            d  = g1 ? r1_wdata : r0_wdata;
            if (we) ref_mem[a] = d;
            else rq.push_back('{due: cyc + LAT, id: g1, data: ref_mem[a]});
            last_addr  = a;
            last_wdata = d;
            last_r1    = g1;
        end
        case (lk)
            0: if (r1_lock) lk = 1;
            1: if (!r1_lock) lk = 0; else if (r0_out == 0) lk = 2;
            default: if (!r1_lock) lk = 0;
        endcase
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        cyc++;
    endtask

    task automatic step_end();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit lock);
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
        r1_lock  = lock;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1, 1, 14'h3, 32'h1, 1, 1, 14'h4, 32'h2, 1);
        #1;
        checks++; if (dut_ctl !== 6'b0) $display("FAIL reset_ctl got=%b want=%b", dut_ctl, 6'b0); else passed++;
        checks++; if (dut_rd !== 64'b0) $display("FAIL reset_rdata got=%h want=0", dut_rd); else passed++;
        checks++; if (dut_port !== '0) $display("FAIL reset_port got=%h want=0", dut_port); else passed++;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        $display("reset: ctl=%b rdata=%h port=%h", dut_ctl, dut_rd, dut_port);
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 0, 14'h1, '0, 0, 0, '0, '0, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL single_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL single_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL single_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("single_read cyc=%0d ctl=%b r0_rdata=%h", cyc, dut_ctl, r0_rdata);
            step_end();
        end
    endtask

    task automatic test_priority();
        bit p0 = 1'b1, p1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(p0, 0, 14'h10, '0, p1, 0, 14'h20, '0, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL prio_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL prio_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL prio_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("priority cyc=%0d ctl=%b rdata=%h", cyc, dut_ctl, dut_rd);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            step_end();
        end
    endtask

    task automatic test_write_read();
        for (int c = 0; c < 5; c++) begin
            drive(c == 1, 0, 14'h3, '0, c == 0, 1, 14'h3, 32'h55AA, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL wr_rd_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL wr_rd_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL wr_rd_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("write_read cyc=%0d ctl=%b r0_rdata=%h", cyc, dut_ctl, r0_rdata);
            step_end();
        end
    endtask

    task automatic test_lock();
        bit p0 = 1'b1;
        bit seen_owned = 1'b0;
        for (int c = 0; c < 18; c++) begin
            drive((c == 0) || (c >= 2 && p0), 0, (c == 0) ? 14'h5 : 14'h6, '0,
                  c == 4, 0, 14'h7, '0, (c >= 1 && c < 12));
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL lock_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL lock_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL lock_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("lock cyc=%0d lock=%b ctl=%b", cyc, r1_lock, dut_ctl);
            if (r1_owned === 1'b1) seen_owned = 1'b1;
            if (g0 && c >= 2) p0 = 1'b0;
            step_end();
        end
        checks++; if (seen_owned !== 1'b1) $display("FAIL lock_owned_seen got=%b want=1", seen_owned); else passed++;
    endtask

    task automatic test_back_to_back();
        bit sel;
        for (int c = 0; c < 11; c++) begin
            sel = $urandom_range(0, 1) == 1;
            drive(c < 8 && !sel, 0, AW'($urandom_range(0, 31)), '0,
                  c < 8 && sel, 0, AW'($urandom_range(0, 31)), '0, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL b2b_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL b2b_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL b2b_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("back_to_back cyc=%0d ctl=%b rdata=%h", cyc, dut_ctl, dut_rd);
            step_end();
        end
    endtask

    task automatic test_random();
        bit p0 = 1'b0, p1 = 1'b0, lock = 1'b0;
        bit we0, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 100; c++) begin
            if (!p0 && c < 80 && $urandom_range(0, 9) < 6) begin
                p0 = 1'b1; we0 = $urandom_range(0, 2) == 0;
                a0 = AW'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && c < 80 && $urandom_range(0, 9) < 6) begin
                p1 = 1'b1; we1 = $urandom_range(0, 2) == 0;
                a1 = AW'($urandom_range(0, 31)); d1 = $urandom;
            end
            if ($urandom_range(0, 9) == 0) lock = ~lock;
            if (c >= 80) lock = 1'b0;
            drive(p0, we0, a0, d0, p1, we1, a1, d1, lock);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_rd !== exp_rd) $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, dut_rd, exp_rd); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL rand_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("random cyc=%0d lock=%b ctl=%b rdata=%h", cyc, lock, dut_ctl, dut_rd);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            step_end();
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 2; c++) begin
            drive(c == 0, 0, 14'h2, '0, c == 1, 0, 14'h3, '0, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL rstfl_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            step_end();
        end
        drive(1, 1, 14'h9, 32'h77, 1, 0, 14'hA, '0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dut_ctl !== 6'b0) $display("FAIL rstfl_async_ctl got=%b want=%b", dut_ctl, 6'b0); else passed++;
        checks++; if (dut_rd !== 64'b0) $display("FAIL rstfl_async_rdata got=%h want=0", dut_rd); else passed++;
        checks++; if (dut_port !== '0) $display("FAIL rstfl_async_port got=%h want=0", dut_port); else passed++;
        $display("reset_inflight async ctl=%b port=%h", dut_ctl, dut_port);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (dut_ctl !== 6'b0) $display("FAIL rstfl_hold_ctl got=%b want=%b", dut_ctl, 6'b0); else passed++;
        end
        release_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
            @(negedge clk);
            model_eval();
            checks++; if (dut_ctl !== exp_ctl) $display("FAIL rstfl_after_ctl cyc=%0d got=%b want=%b", cyc, dut_ctl, exp_ctl); else passed++;
            checks++; if (dut_port !== exp_port) $display("FAIL rstfl_after_port cyc=%0d got=%h want=%h", cyc, dut_port, exp_port); else passed++;
            $display("reset_inflight after cyc=%0d ctl=%b", cyc, dut_ctl);
            step_end();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        model_reset();
        for (int i = 0; i < 32; i++) preload(AW'(i), $urandom);
        preload(14'h1, 32'hDEADBEEF);
        preload(14'h10, 32'h1010_1010);
        preload(14'h20, 32'h2020_2020);
        test_reset();
        release_reset();
        test_single_read();
        test_priority();
        test_write_read();
        test_lock();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
